// File: rtl/tdm_demux.sv
// 1-to-LANES TDM demux: collects one framed beat per slot and publishes a whole frame atomically.
// Registered outputs; dout/dout_vld appear the cycle after the last beat; no backpressure (din_vld only).
module tdm_demux #(
  parameter int WIDTH = 1,
  parameter int LANES = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [WIDTH-1:0]                           din,
  input  logic                                       din_vld,
  input  logic                                       sof,
  output logic [LANES*WIDTH-1:0]                     dout,
  output logic                                       dout_vld,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] sel,
  output logic                                       frm_err
);

  localparam int SELW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [SELW-1:0] SEL_LAST = SELW'(LANES - 1);
  localparam logic [SELW-1:0] SEL_ONE  = SELW'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [SELW-1:0]          sel_q, sel_d;
  logic [LANES*WIDTH-1:0]   shadow_q, shadow_d;
  logic [LANES*WIDTH-1:0]   dout_q, dout_d;
  logic                     dout_vld_q, dout_vld_d;
  logic                     frm_err_q, frm_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      shadow_q   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      shadow_q   <= shadow_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      frm_err_q  <= frm_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    frm_err_d  = 1'b0;

    if (din_vld) begin
      case (state_q)
        IDLE: begin
          // Beats without sof here are orphans from a lost frame; drop them silently.
          if (sof) begin
            if (LANES == 1) begin
              dout_d                                   = shadow_q;
              dout_d[(LANES-1)*WIDTH +: WIDTH]         = din;
              dout_vld_d                               = 1'b1;
              sel_d                                    = '0;
            end else begin
              shadow_d[WIDTH-1:0] = din;
              sel_d               = SEL_ONE;
              state_d             = COLLECT;
            end
          end
        end

        COLLECT: begin
          if (sof) begin
            // Early sof: abandon the partial frame and restart it with this beat as slot 0.
            frm_err_d           = 1'b1;
            shadow_d[WIDTH-1:0] = din;
            sel_d               = SEL_ONE;
          end else if (sel_q == SEL_LAST) begin
            dout_d                           = shadow_q;
            dout_d[(LANES-1)*WIDTH +: WIDTH] = din;
            dout_vld_d                       = 1'b1;
            sel_d                            = '0;
            state_d                          = IDLE;
          end else begin
            for (int k = 0; k < LANES; k++) begin
              if (sel_q == SELW'(k)) begin
                shadow_d[k*WIDTH +: WIDTH] = din;
              end
            end
            sel_d = sel_q + SEL_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          sel_d   = '0;
        end
      endcase
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign sel      = sel_q;
  assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux at WIDTH=1, LANES=2 with hand-computed expectations.
module tb_tdm_demux;

  logic       clk;
  logic       rst;
  logic [0:0] din;
  logic       din_vld;
  logic       sof;
  logic [1:0] dout;
  logic       dout_vld;
  logic [0:0] sel;
  logic       frm_err;

  int n_cmp;
  int n_bad;

  tdm_demux #(.WIDTH(1), .LANES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .sof      (sof),
    .dout     (dout),
    .dout_vld (dout_vld),
    .sel      (sel),
    .frm_err  (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then settle just past the rising edge.
  task automatic step(input logic v, input logic s, input logic d);
    @(negedge clk);
    din_vld = v;
    sof     = s;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_dout, input logic e_vld,
                         input logic e_sel, input logic e_err);
    chk({tag, ".dout"},     {30'd0, dout},     {30'd0, e_dout});
    chk({tag, ".dout_vld"}, {31'd0, dout_vld}, {31'd0, e_vld});
    chk({tag, ".sel"},      {31'd0, sel},      {31'd0, e_sel});
    chk({tag, ".frm_err"},  {31'd0, frm_err},  {31'd0, e_err});
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    din     = 1'b0;
    din_vld = 1'b0;
    sof     = 1'b0;
    #3;
    chk_all("reset0", 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single frame {1,0}
    step(1'b1, 1'b1, 1'b1);
    chk_all("single.b0", 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_all("single.b1", 2'b01, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("single.after", 2'b01, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames {1,1} then {0,1}
    step(1'b1, 1'b1, 1'b1);
    chk_all("b2b.f0b0", 2'b01, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk_all("b2b.f0b1", 2'b11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("b2b.f1b0", 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk_all("b2b.f1b1", 2'b10, 1'b1, 1'b0, 1'b0);

    // Gap of three idle cycles mid-frame; first load 2'b01 so the publish is visible
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk_all("gap.pre", 2'b01, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("gap.sof", 2'b01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk_all($sformatf("gap.idle%0d", i), 2'b01, 1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1);
    chk_all("gap.last", 2'b10, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("gap.after", 2'b10, 1'b0, 1'b0, 1'b0);

    // Truncation with dout=2'b11 held
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk_all("trunc.pre", 2'b11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk_all("trunc.sof1", 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("trunc.sof2", 2'b11, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk_all("trunc.last", 2'b10, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("trunc.after", 2'b10, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame, asserted between clock edges
    step(1'b1, 1'b1, 1'b1);
    chk_all("rstmid.sof", 2'b10, 1'b0, 1'b1, 1'b0);
    din_vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("rstmid.async", 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    chk_all("orphan", 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("post.b0", 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk_all("post.b1", 2'b10, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("post.after", 2'b10, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
